// File: rtl/uvmt_apb_st_pkg.sv
// rtl/uvmt_apb_st_pkg.sv - shared types and default widths for the APB self-test master arbiter
package uvmt_apb_st_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } uvmt_apb_st_mstr_arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/uvmt_apb_st_rr_arb.sv
// rtl/uvmt_apb_st_rr_arb.sv - combinational round-robin picker; pointer register lives in the parent
module uvmt_apb_st_rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W:0] cand;
  logic           found;

  // Search last_grant+1 .. last_grant+N; one conditional subtract is enough since the sum stays below 2N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (enable && !found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uvmt_apb_st_mstr_arb.sv
// rtl/uvmt_apb_st_mstr_arb.sv - round-robin requester arbiter driving one APB master port
module uvmt_apb_st_mstr_arb
  import uvmt_apb_st_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          rsp_timeout,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  uvmt_apb_st_mstr_arb_state_t state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;

  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_slverr_d, rsp_timeout_d;

  uvmt_apb_st_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (state_q == IDLE),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr;
    pwrite_d      = pwrite;
    pwdata_d      = pwdata;
    psel_d        = psel;
    penable_d     = penable;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (|gnt) begin
          paddr_d      = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d     = req_write[gnt_idx];
          pwdata_d     = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          last_grant_d = gnt_idx;
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is checked first so a completion on the final allowed cycle is never reported as a timeout.
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = NUM_REQ'(1) << last_grant_q;
          if (!pwrite) begin
            rsp_rdata_d = prdata;
          end
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = NUM_REQ'(1) << last_grant_q;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_slverr   <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      paddr        <= paddr_d;
      pwrite       <= pwrite_d;
      pwdata       <= pwdata_d;
      psel         <= psel_d;
      penable      <= penable_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_slverr   <= rsp_slverr_d;
      rsp_timeout  <= rsp_timeout_d;
    end
  end

endmodule

// File: doc/uvmt_apb_st_mstr_arb.md
Name: uvmt_apb_st_mstr_arb

Overview:
- Synthesizable APB requester arbiter and master sequencer for the APB self-test environment.
- Accepts simple valid/ready transfer requests from NUM_REQ local requesters.
- Grants one requester at a time in round-robin order and drives a single APB master port through the SETUP and ACCESS phases.
- Returns read data and error/timeout status to the granted requester.
- Sits between test stimulus sources and the master-side APB interface of the self-test DUT wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width.
- TIMEOUT_CYCLES, 256, max ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed request addresses, requester i at slice i.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_slverr  out  1  pslverr seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Interface fixed: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - psel, penable, pwrite, req_ready, rsp_valid, rsp_slverr, rsp_timeout = 0.
  - paddr, pwdata, rsp_rdata = 0.
  - FSM = IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- All APB and rsp outputs are registered. req_ready is combinational from state and req_valid.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: if any req_valid, pick g = first asserted index searching last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ).
    - Assert req_ready[g] this cycle.
    - Latch addr, write, wdata into paddr/pwrite/pwdata; set last_grant = g.
    - Next cycle: state SETUP with psel=1, penable=0.
    - No req_valid: stay IDLE, psel=0.
  - SETUP: exactly one cycle. Next: ACCESS, psel=1, penable=1. Clear timeout counter.
  - ACCESS, pready=1 sampled:
    - Next cycle: psel=0, penable=0, rsp_valid[g]=1.
    - rsp_rdata=prdata (reads only; writes leave rsp_rdata unchanged), rsp_slverr=pslverr, rsp_timeout=0.
    - State IDLE.
  - ACCESS, pready=0: increment counter. When TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1:
    - Next cycle: psel=0, penable=0, rsp_valid[g]=1, rsp_slverr=1, rsp_timeout=1.
    - State IDLE.
  - pready and timeout in the same cycle: pready wins, normal completion.
- Minimum transfer: accept(IDLE) → SETUP → ACCESS = 3 cycles. rsp_valid appears in the cycle after the pready cycle.
- A new grant may occur in the same cycle rsp_valid pulses (state IDLE).
- paddr, pwrite, pwdata hold stable from SETUP through the end of ACCESS, and keep their last value while idle.
- Requester contract:
  - Hold req_valid and payload stable until req_ready.
  - Must not re-request before its rsp_valid.
  - Dropping req_valid before acceptance is legal; the requester is simply skipped.
- Reset mid-transfer: all outputs return to reset values immediately; the pending transfer is lost and no rsp_valid is issued.
- Timeout counter width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Decomposition:
- Shared package uvmt_apb_st_pkg holds:
  - typedef enum logic[1:0] {IDLE, SETUP, ACCESS} uvmt_apb_st_mstr_arb_state_t.
  - Default width constants.
- Sub-module uvmt_apb_st_rr_arb: parameter N.
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot gnt and gnt_idx.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read, requester 2 at addr 0x10, slave pready after 2 wait states, prdata=0xCAFE0001 → psel high 4 cycles, penable 3 cycles, rsp_valid[2] pulse with rsp_rdata=0xCAFE0001, slverr=0.
- All 4 requesters valid simultaneously from reset, zero-wait slave → grant order 0,1,2,3; each rsp_valid in the same order; no cycle with psel=0 between transfers other than the single IDLE cycle.
- Write addr 0x20, data 0x55AA, pslverr=1 on completion → pwrite=1, pwdata=0x55AA stable through ACCESS, rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=8, pready held 0 → abort after 8 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, FSM returns IDLE and serves the next request.
- pready asserted on the exact timeout cycle → normal completion, rsp_timeout=0.
- reset asserted during ACCESS → psel/penable/rsp_valid drop asynchronously to 0, no response issued; after release, requester 0 is granted first.
